// File: rtl/drive_pkg.sv
// Shared types for the dual H-bridge PWM driver: direction codes, FSM states,
// bridge polarity encoding and the speed-to-duty table.
package drive_pkg;

  localparam int DUTY_W = 16;

  typedef enum logic [2:0] {
    DIR_STOP  = 3'd0,
    DIR_FWD   = 3'd1,
    DIR_REV   = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } drv_state_e;

  localparam logic [1:0] BR_FWD   = 2'b10;
  localparam logic [1:0] BR_REV   = 2'b01;
  localparam logic [1:0] BR_COAST = 2'b00;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] r;
  } pol_t;

  localparam pol_t POL_COAST = '{l: BR_COAST, r: BR_COAST};

  // Codes 5..7 are not commands and fall back to STOP.
  function automatic dir_e decode_dir(input logic [2:0] raw);
    dir_e d;
    case (raw)
      3'd1:    d = DIR_FWD;
      3'd2:    d = DIR_REV;
      3'd3:    d = DIR_LEFT;
      3'd4:    d = DIR_RIGHT;
      default: d = DIR_STOP;
    endcase
    return d;
  endfunction

  function automatic pol_t dir_polarity(input dir_e d);
    pol_t p;
    case (d)
      DIR_FWD:   p = '{l: BR_FWD, r: BR_FWD};
      DIR_REV:   p = '{l: BR_REV, r: BR_REV};
      DIR_LEFT:  p = '{l: BR_REV, r: BR_FWD};
      DIR_RIGHT: p = '{l: BR_FWD, r: BR_REV};
      default:   p = POL_COAST;
    endcase
    return p;
  endfunction

  function automatic logic [DUTY_W-1:0] speed_duty(input logic [1:0] speed);
    logic [DUTY_W-1:0] duty;
    case (speed)
      2'd1:    duty = DUTY_W'(1000);
      2'd2:    duty = DUTY_W'(1750);
      2'd3:    duty = DUTY_W'(2500);
      default: duty = '0;
    endcase
    return duty;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One motor channel: duty ramp toward target, period-aligned shadow duty and
// registered compare against the shared PWM counter.
module pwm_channel
  import drive_pkg::*;
#(
  parameter int RAMP_STEP = 125
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              tick,
  input  logic              load,
  input  logic [DUTY_W-1:0] target,
  input  logic [DUTY_W-1:0] cnt_next,
  output logic              pwm
);

  localparam logic [DUTY_W:0] STEP = (DUTY_W + 1)'(RAMP_STEP);

  logic [DUTY_W-1:0] ramp_duty;
  logic [DUTY_W-1:0] active_duty;
  logic [DUTY_W-1:0] ramp_next;
  logic [DUTY_W-1:0] active_next;

  // One step toward tgt, landing exactly on tgt rather than overshooting.
  function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic [DUTY_W-1:0] tgt);
    logic [DUTY_W:0] up;
    logic [DUTY_W:0] gap;
    logic [DUTY_W-1:0] res;
    up  = {1'b0, cur} + STEP;
    gap = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      res = (up >= {1'b0, tgt}) ? tgt : up[DUTY_W-1:0];
    end else begin
      res = (gap <= STEP) ? tgt : (cur - STEP[DUTY_W-1:0]);
    end
    return res;
  endfunction

  always_comb begin
    ramp_next   = ramp_duty;
    active_next = active_duty;
    if (!run) begin
      ramp_next   = '0;
      active_next = '0;
    end else begin
      if (tick) ramp_next = step_toward(ramp_duty, target);
      if (load) active_next = ramp_duty;
    end
  end

  // Compare uses next-cycle values so pwm lines up with the registered counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_duty   <= '0;
      active_duty <= '0;
      pwm         <= 1'b0;
    end else begin
      ramp_duty   <= ramp_next;
      active_duty <= active_next;
      pwm         <= run && (cnt_next < active_next);
    end
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge driver: command latch, IDLE/DRIVE/DEAD sequencing with coast
// on polarity change, shared PWM counter, ramp divider and command watchdog.
module motor_pwm_driver
  import drive_pkg::*;
#(
  parameter int PWM_PERIOD  = 2500,
  parameter int DEAD_CYCLES = 50000,
  parameter int RAMP_DIV    = 5000,
  parameter int RAMP_STEP   = 125,
  parameter int WDT_CYCLES  = 25000000
) (
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_dir,
  input  logic [1:0] cmd_speed,
  output logic [1:0] dir_l,
  output logic [1:0] dir_r,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] drv_state,
  output logic       wdt_fault
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam int WDT_W  = $clog2(WDT_CYCLES + 1);
  localparam int DIV_W  = $clog2(RAMP_DIV + 1);

  drv_state_e        state;
  drv_state_e        state_next;
  pol_t              drive_pol;
  pol_t              drive_pol_next;
  pol_t              pend_pol;
  pol_t              pend_pol_next;
  pol_t              pol_in;
  logic [DEAD_W-1:0] dead_cnt;
  logic [DEAD_W-1:0] dead_cnt_next;
  logic [WDT_W-1:0]  wdt_cnt;
  logic [DIV_W-1:0]  div_cnt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] pwm_cnt_next;
  logic [DUTY_W-1:0] target;
  dir_e              dir_in;
  dir_e              cmd_dir_q;
  logic [1:0]        cmd_speed_q;
  logic              stop_in;
  logic              wdt_expire;
  logic              halt;
  logic              tick;
  logic              period_end;
  logic              run_next;

  assign dir_in     = decode_dir(cmd_dir);
  assign stop_in    = (dir_in == DIR_STOP);
  assign pol_in     = dir_polarity(dir_in);
  // A command arriving on the expiry cycle reloads instead of faulting.
  assign wdt_expire = !cmd_valid && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
  assign halt       = wdt_expire || (cmd_valid && stop_in);

  always_comb begin
    state_next     = state;
    drive_pol_next = drive_pol;
    pend_pol_next  = pend_pol;
    dead_cnt_next  = dead_cnt;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && !stop_in) begin
          state_next    = ST_DEAD;
          pend_pol_next = pol_in;
          dead_cnt_next = '0;
        end
      end
      ST_DRIVE: begin
        if (halt) begin
          state_next     = ST_IDLE;
          drive_pol_next = POL_COAST;
        end else if (cmd_valid && (pol_in != drive_pol)) begin
          state_next     = ST_DEAD;
          drive_pol_next = POL_COAST;
          pend_pol_next  = pol_in;
          dead_cnt_next  = '0;
        end
      end
      ST_DEAD: begin
        if (halt) begin
          state_next    = ST_IDLE;
          dead_cnt_next = '0;
        end else if (cmd_valid && (pol_in != pend_pol)) begin
          pend_pol_next = pol_in;
          dead_cnt_next = '0;
        end else if (dead_cnt == DEAD_W'(DEAD_CYCLES - 1)) begin
          state_next     = ST_DRIVE;
          drive_pol_next = pend_pol;
          dead_cnt_next  = '0;
        end else begin
          dead_cnt_next = dead_cnt + DEAD_W'(1);
        end
      end
      default: begin
        state_next     = ST_IDLE;
        drive_pol_next = POL_COAST;
        dead_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drive_pol <= POL_COAST;
      pend_pol  <= POL_COAST;
      dead_cnt  <= '0;
    end else begin
      state     <= state_next;
      drive_pol <= drive_pol_next;
      pend_pol  <= pend_pol_next;
      dead_cnt  <= dead_cnt_next;
    end
  end

  // Command latch and watchdog; the counter saturates so expiry fires once.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      cmd_dir_q   <= DIR_STOP;
      cmd_speed_q <= 2'd0;
      wdt_cnt     <= '0;
      wdt_fault   <= 1'b0;
    end else begin
      if (cmd_valid) begin
        cmd_dir_q   <= dir_in;
        cmd_speed_q <= cmd_speed;
        wdt_cnt     <= '0;
        wdt_fault   <= 1'b0;
      end else begin
        if (wdt_cnt != WDT_W'(WDT_CYCLES)) wdt_cnt <= wdt_cnt + WDT_W'(1);
        if (wdt_expire) begin
          cmd_dir_q <= DIR_STOP;
          wdt_fault <= 1'b1;
        end
      end
    end
  end

  assign period_end   = (pwm_cnt == DUTY_W'(PWM_PERIOD - 1));
  assign pwm_cnt_next = period_end ? '0 : (pwm_cnt + DUTY_W'(1));
  assign tick         = (state == ST_DRIVE) && (div_cnt == DIV_W'(RAMP_DIV - 1));
  assign run_next     = (state_next == ST_DRIVE);
  assign target       = (cmd_dir_q == DIR_STOP) ? '0 : speed_duty(cmd_speed_q);

  // Ramp divider restarts on DRIVE entry so the first step lands RAMP_DIV clocks in.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt_next;
      if (!run_next || (state != ST_DRIVE) || tick) div_cnt <= '0;
      else div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_l (
    .clk      (clk_50),
    .rst_n    (rst_n),
    .run      (run_next),
    .tick     (tick),
    .load     (period_end),
    .target   (target),
    .cnt_next (pwm_cnt_next),
    .pwm      (pwm_l)
  );

  pwm_channel #(.RAMP_STEP(RAMP_STEP)) u_chan_r (
    .clk      (clk_50),
    .rst_n    (rst_n),
    .run      (run_next),
    .tick     (tick),
    .load     (period_end),
    .target   (target),
    .cnt_next (pwm_cnt_next),
    .pwm      (pwm_r)
  );

  assign dir_l     = drive_pol.l;
  assign dir_r     = drive_pol.r;
  assign drv_state = state;

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 2500, PWM counter modulus in clocks (20 kHz at 50 MHz).
REQ-002 SHALL have parameter DEAD_CYCLES, default 50000, coast interval in clocks on any polarity change (1 ms).
REQ-003 SHALL have parameter RAMP_DIV, default 5000, clocks between duty ramp steps.
REQ-004 SHALL have parameter RAMP_STEP, default 125, duty increment per ramp step.
REQ-005 SHALL have parameter WDT_CYCLES, default 25000000, command watchdog timeout in clocks (0.5 s).
REQ-006 SHALL have port clk_50, input, 1, sole clock; one clock domain; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port cmd_valid, input, 1, one-cycle strobe qualifying cmd_dir and cmd_speed.
REQ-009 SHALL have port cmd_dir, input, 3, 0 STOP, 1 FWD, 2 REV, 3 LEFT, 4 RIGHT; 5-7 treated as STOP.
REQ-010 SHALL have port cmd_speed, input, 2, speed level from the drive FSM.
REQ-011 SHALL have port dir_l, output, 2, left H-bridge {in1,in2}: 10 forward, 01 reverse, 00 coast.
REQ-012 SHALL have port dir_r, output, 2, right H-bridge, same encoding.
REQ-013 SHALL have port pwm_l, output, 1, left enable PWM.
REQ-014 SHALL have port pwm_r, output, 1, right enable PWM.
REQ-015 SHALL have port drv_state, output, 2, 0 IDLE, 1 DRIVE, 2 DEAD.
REQ-016 SHALL have port wdt_fault, output, 1, sticky watchdog-expired flag.

Function
REQ-017 SHALL sample cmd_dir/cmd_speed only on cycles with cmd_valid=1; other cycles hold the last accepted command.
REQ-018 SHALL map cmd_speed 0/1/2/3 to target duty 0/1000/1750/2500; STOP forces target 0 regardless of speed.
REQ-019 SHALL map polarity: FWD L10 R10; REV L01 R01; LEFT L01 R10; RIGHT L10 R01; STOP L00 R00.
REQ-020 SHALL run one free counter 0..PWM_PERIOD-1, wrapping to 0; pwm_x = (cnt < active_duty_x) and state==DRIVE.
REQ-021 SHALL load active_duty_x from ramp_duty_x only when cnt==PWM_PERIOD-1 (glitch-free period update).
REQ-022 SHALL move ramp_duty_x toward target by RAMP_STEP every RAMP_DIV clocks, clamped exactly at target, in both directions.
REQ-023 SHALL implement FSM IDLE/DRIVE/DEAD with these transitions:
  - IDLE -> DEAD on accepted non-STOP command;
  - DRIVE -> DEAD on accepted command whose polarity differs from the current polarity;
  - DRIVE stays DRIVE on same-polarity command (ramp only);
  - DRIVE or DEAD -> IDLE on STOP or watchdog expiry;
  - DEAD -> DRIVE after DEAD_CYCLES clocks.
REQ-024 SHALL, in DEAD and IDLE: dir_x=00, pwm_x=0, ramp_duty_x=active_duty_x=0; polarity latches on DEAD->DRIVE.
REQ-025 SHALL restart the DEAD count from 0 if a further polarity-changing command arrives during DEAD; the latest command wins.
REQ-026 SHALL make STOP take effect the cycle after cmd_valid: dir_x=00, pwm_x=0, no ramp-down.
REQ-027 SHALL reload the watchdog on every cmd_valid; on reaching WDT_CYCLES it forces the STOP path and sets wdt_fault.
REQ-028 SHALL clear wdt_fault on the next cmd_valid; cmd_valid in the same cycle as expiry counts as a reload, with no fault.
REQ-029 SHALL register all outputs; output latency from a cmd_valid edge to a drv_state change is 1 clock.

Reset
REQ-030 SHALL, while rst_n=0: dir_l=dir_r=00, pwm_l=pwm_r=0, drv_state=IDLE, wdt_fault=0, all counters and duties 0, stored command STOP.
REQ-031 SHALL, on rst_n assertion mid-DRIVE or mid-DEAD, drop outputs asynchronously with no ramp-down; after release, remain in IDLE until the first cmd_valid.

Structure
REQ-032 SHALL place the direction enum, FSM state enum and speed-to-duty table in shared package drive_pkg, also used by the FSM block.
REQ-033 SHALL implement per-motor ramp, shadow duty and compare as sub-module pwm_channel, instantiated twice; the PWM counter, FSM and watchdog live in the parent.

Verification
REQ-034 SHALL cover: reset, then cmd FWD speed 3 -> DEAD for 50000 clocks; then DRIVE with dir_l=dir_r=10; duty ramps 125 per 5000 clocks to 2500 (pwm constantly high).
REQ-035 SHALL cover: in DRIVE FWD speed 3, cmd FWD speed 1 -> no DEAD; duty ramps down to 1000; pwm_l high for 1000 of 2500 clocks per period.
REQ-036 SHALL cover: in DRIVE FWD, cmd LEFT -> next cycle DEAD with dir=00 and pwm=0; after 50000 clocks dir_l=01, dir_r=10, ramp restarts from 0.
REQ-037 SHALL cover: in DEAD, a second polarity command at clock 30000 -> DEAD extends to 50000 clocks after the second command; final polarity from the second command.
REQ-038 SHALL cover: no cmd_valid for 25000000 clocks -> IDLE, outputs 0, wdt_fault=1; next cmd_valid clears wdt_fault.
REQ-039 SHALL cover: rst_n pulsed low mid-DRIVE -> outputs 0 immediately without a clock edge; IDLE after release.
